// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit multiplexed seven-segment scan with frame-synchronous shadow commit
// Optional feature: define LEADING_ZERO_BLANK_EN to darken leading zero digits.
module display_scan_controller #(
    parameter int CLK_DIV     = 12500,
    parameter int DEAD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_sel,
    output logic       load_ready,
    output logic [1:0] digit_sel,
    output logic [3:0] digit_en_n,
    output logic [3:0] nibble,
    output logic       blank
);

    localparam int CNT_MAX = (CLK_DIV > DEAD_CYCLES) ? CLK_DIV : DEAD_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES == 0) ? 0 : DEAD_CYCLES - 1);

    typedef enum logic {SHOW, DEAD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          live_q, live_d;
    logic [1:0]    digit_sel_q, digit_sel_d;
    logic [15:0]   display_q, display_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          load_ready_q, load_ready_d;
    logic [3:0]    digit_en_n_q, digit_en_n_d;
    logic [3:0]    nibble_q, nibble_d;
    logic          blank_q, blank_d;
    logic          advance;
    logic          suppress;
    logic          lit;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        live_d       = 1'b1;
        digit_sel_d  = digit_sel_q;
        display_d    = display_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        advance      = 1'b0;

        // live_q is low only in the cycle held by reset; the next edge starts digit 0's SHOW
        if (!live_q) begin
            state_d     = SHOW;
            cnt_d       = '0;
            digit_sel_d = 2'd0;
        end else if (state_q == SHOW) begin
            if (cnt_q == SHOW_LAST) begin
                cnt_d       = '0;
                digit_sel_d = digit_sel_q + 2'd1;
                advance     = 1'b1;
                state_d     = (DEAD_CYCLES == 0) ? SHOW : DEAD;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == DEAD_LAST) begin
                cnt_d   = '0;
                state_d = SHOW;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Commit only where digit_sel wraps 3->0 so a frame never mixes old and new digits
        if (advance && (digit_sel_q == 2'd3) && pending_q) begin
            display_d = shadow_q;
            pending_d = 1'b0;
        end else if (load_valid && load_ready_q) begin
            if (load_sel) begin
                shadow_d[15:8] = load_data;
            end else begin
                shadow_d[7:0] = load_data;
            end
            pending_d = 1'b1;
        end

`ifdef LEADING_ZERO_BLANK_EN
        case (digit_sel_d)
            2'd3:    suppress = (display_d[15:12] == 4'h0);
            2'd2:    suppress = (display_d[15:8] == 8'h00);
            2'd1:    suppress = (display_d[15:4] == 12'h000);
            default: suppress = 1'b0;
        endcase
`else
        suppress = 1'b0;
`endif

        lit          = (state_d == SHOW) && !suppress;
        digit_en_n_d = lit ? ~(4'b0001 << digit_sel_d) : 4'b1111;
        blank_d      = !lit;
        nibble_d     = display_d[{digit_sel_d, 2'b00} +: 4];
        load_ready_d = !pending_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SHOW;
            cnt_q        <= '0;
            live_q       <= 1'b0;
            digit_sel_q  <= 2'd0;
            display_q    <= 16'h0000;
            shadow_q     <= 16'h0000;
            pending_q    <= 1'b0;
            load_ready_q <= 1'b1;
            digit_en_n_q <= 4'b1111;
            nibble_q     <= 4'h0;
            blank_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            live_q       <= live_d;
            digit_sel_q  <= digit_sel_d;
            display_q    <= display_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            load_ready_q <= load_ready_d;
            digit_en_n_q <= digit_en_n_d;
            nibble_q     <= nibble_d;
            blank_q      <= blank_d;
        end
    end

    assign load_ready = load_ready_q;
    assign digit_sel  = digit_sel_q;
    assign digit_en_n = digit_en_n_q;
    assign nibble     = nibble_q;
    assign blank      = blank_q;

endmodule
